// File: rtl/frame_ones_pkg.sv
// Shared types and width helpers for the frame ones counter.
package frame_ones_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width_f(input int data_width, input int max_words);
    return $clog2(data_width * max_words + 1);
  endfunction

  function automatic int wcnt_width_f(input int max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/word_popcount.sv
// Combinational count of the 1 bits in a single input word.
module word_popcount #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic [DATA_WIDTH-1:0] din,
  output logic [OUT_WIDTH-1:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      count = count + OUT_WIDTH'(din[i]);
    end
  end

endmodule

// File: rtl/frame_ones_counter.sv
// Frame-level ones counter: accumulates per-word popcounts and returns one result per frame.
// Optional threshold compare output enabled by FRAME_ONES_THRESH_EN.
//
// state | meaning
// IDLE  | no beats of the current frame accepted yet
// ACCUM | at least one beat accepted, frame still open
// DONE  | result held on dout until dout_ready
module frame_ones_counter
  import frame_ones_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WORDS  = 8,
  parameter int CNT_WIDTH  = cnt_width_f(DATA_WIDTH, MAX_WORDS),
  parameter int WCNT_WIDTH = wcnt_width_f(MAX_WORDS)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  din_last,
  output logic                  din_ready,
  output logic [CNT_WIDTH-1:0]  dout,
  output logic [WCNT_WIDTH-1:0] dout_words,
  output logic                  dout_trunc,
  output logic                  dout_valid,
`ifdef FRAME_ONES_THRESH_EN
  input  logic [CNT_WIDTH-1:0]  thresh,
  output logic                  dout_above,
`endif
  input  logic                  dout_ready
);

  localparam int PC_WIDTH = $clog2(DATA_WIDTH) + 1;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  acc, total;
  logic [WCNT_WIDTH-1:0] wcnt, wcnt_inc;
  logic [PC_WIDTH-1:0]   pc;
  logic                  accept, frame_end;

  word_popcount #(
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_WIDTH (PC_WIDTH)
  ) u_popcount (
    .din  (din),
    .count(pc)
  );

  assign din_ready  = (state != DONE);
  assign dout_valid = (state == DONE);
  assign accept     = din_valid && din_ready;
  assign wcnt_inc   = wcnt + WCNT_WIDTH'(1);
  // Reaching the word limit closes the frame even without din_last.
  assign frame_end  = din_last || (wcnt_inc == WCNT_WIDTH'(MAX_WORDS));
  assign total      = acc + CNT_WIDTH'(pc);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: if (accept) state_nxt = frame_end ? DONE : ACCUM;
      DONE:        if (dout_ready) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc        <= '0;
      wcnt       <= '0;
      dout       <= '0;
      dout_words <= '0;
      dout_trunc <= 1'b0;
`ifdef FRAME_ONES_THRESH_EN
      dout_above <= 1'b0;
`endif
    end else if (accept) begin
      if (frame_end) begin
        dout       <= total;
        dout_words <= wcnt_inc;
        dout_trunc <= !din_last;
        acc        <= '0;
        wcnt       <= '0;
`ifdef FRAME_ONES_THRESH_EN
        dout_above <= (total > thresh);
`endif
      end else begin
        acc  <= total;
        wcnt <= wcnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_frame_ones_counter.sv
// Self-checking bench for frame_ones_counter (DATA_WIDTH=8, MAX_WORDS=4); covers FRAME_ONES_THRESH_EN when defined.
module tb_frame_ones_counter;

  localparam int DW = 8;
  localparam int MW = 4;
  localparam int CW = $clog2(DW * MW + 1);
  localparam int WW = $clog2(MW + 1);

  logic          clk;
  logic          resetn;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_last;
  logic          din_ready;
  logic [CW-1:0] dout;
  logic [WW-1:0] dout_words;
  logic          dout_trunc;
  logic          dout_valid;
  logic          dout_ready;
`ifdef FRAME_ONES_THRESH_EN
  logic [CW-1:0] thresh;
  logic          dout_above;
`endif

  int total = 0;
  int bad   = 0;

  frame_ones_counter #(.DATA_WIDTH(DW), .MAX_WORDS(MW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .din       (din),
    .din_valid (din_valid),
    .din_last  (din_last),
    .din_ready (din_ready),
    .dout      (dout),
    .dout_words(dout_words),
    .dout_trunc(dout_trunc),
    .dout_valid(dout_valid),
`ifdef FRAME_ONES_THRESH_EN
    .thresh    (thresh),
    .dout_above(dout_above),
`endif
    .dout_ready(dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic int ones(input logic [DW-1:0] w);
    int n = 0;
    for (int i = 0; i < DW; i++) n += int'(w[i]);
    return n;
  endfunction

  task automatic test_reset;
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL rst_din_ready got=%0b want=1", din_ready); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL rst_dout_valid got=%0b want=0", dout_valid); end
    total++; if (dout !== '0 || dout_words !== '0 || dout_trunc !== 1'b0) begin bad++;
      $display("FAIL rst_outputs got=%0d/%0d/%0b want=0/0/0", dout, dout_words, dout_trunc); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    total++; if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin bad++;
      $display("FAIL post_rst_handshake got ready=%0b valid=%0b want 1/0", din_ready, dout_valid); end
  endtask

  task automatic test_single_beat;
    dout_ready = 1'b1;
    din = 8'hFF; din_last = 1'b1; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0; din_last = 1'b0;
    total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", dout_valid); end
    total++; if (dout !== CW'(8)) begin bad++; $display("FAIL single_dout got=%0d want=8", dout); end
    total++; if (dout_words !== WW'(1) || dout_trunc !== 1'b0) begin bad++;
      $display("FAIL single_words_trunc got=%0d/%0b want=1/0", dout_words, dout_trunc); end
    total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL single_done_ready got=%0b want=0", din_ready); end
    @(negedge clk);
    total++; if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin bad++;
      $display("FAIL single_return got valid=%0b ready=%0b want 0/1", dout_valid, din_ready); end
  endtask

  task automatic test_bubbles;
    dout_ready = 1'b1;
    din = 8'h0F; din_valid = 1'b1; @(negedge clk);
    din_valid = 1'b0;              @(negedge clk);
    din = 8'h01; din_valid = 1'b1; @(negedge clk);
    din_valid = 1'b0;              @(negedge clk);
    total++; if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin bad++;
      $display("FAIL bubble_midframe got ready=%0b valid=%0b want 1/0", din_ready, dout_valid); end
    din = 8'h80; din_last = 1'b1; din_valid = 1'b1; @(negedge clk);
    din_valid = 1'b0; din_last = 1'b0;
    total++; if (dout_valid !== 1'b1 || dout !== CW'(6) || dout_words !== WW'(3) || dout_trunc !== 1'b0) begin bad++;
      $display("FAIL bubble_result got v=%0b d=%0d w=%0d t=%0b want 1/6/3/0", dout_valid, dout, dout_words, dout_trunc); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    dout_ready = 1'b0;
    din = 8'hAA; din_last = 1'b1; din_valid = 1'b1; @(negedge clk);
    din_valid = 1'b0; din_last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total++; if (dout_valid !== 1'b1 || dout !== CW'(4) || din_ready !== 1'b0) begin bad++;
        $display("FAIL bp_hold cyc=%0d got v=%0b d=%0d r=%0b want 1/4/0", k, dout_valid, dout, din_ready); end
      @(negedge clk);
    end
    dout_ready = 1'b1;
    @(negedge clk);
    total++; if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin bad++;
      $display("FAIL bp_release got v=%0b r=%0b want 0/1", dout_valid, din_ready); end
  endtask

  task automatic test_truncation;
    dout_ready = 1'b1;
    din = 8'hFF; din_last = 1'b0; din_valid = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (dout_valid !== 1'b1 || dout !== CW'(32) || dout_words !== WW'(4) || dout_trunc !== 1'b1) begin bad++;
      $display("FAIL trunc_result got v=%0b d=%0d w=%0d t=%0b want 1/32/4/1", dout_valid, dout, dout_words, dout_trunc); end
    total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL trunc_ready got=%0b want=0", din_ready); end
    din_last = 1'b1;
    @(negedge clk);
    total++; if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin bad++;
      $display("FAIL trunc_return got v=%0b r=%0b want 0/1", dout_valid, din_ready); end
    @(negedge clk);
    din_valid = 1'b0; din_last = 1'b0;
    total++; if (dout_valid !== 1'b1 || dout !== CW'(8) || dout_words !== WW'(1) || dout_trunc !== 1'b0) begin bad++;
      $display("FAIL trunc_next got v=%0b d=%0d w=%0d t=%0b want 1/8/1/0", dout_valid, dout, dout_words, dout_trunc); end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    dout_ready = 1'b1;
    din = 8'hFF; din_valid = 1'b1;
    repeat (2) @(negedge clk);
    din_valid = 1'b0;
    resetn = 1'b0;
    #1;
    total++; if (din_ready !== 1'b1 || dout_valid !== 1'b0 || dout !== '0 || dout_words !== '0) begin bad++;
      $display("FAIL midrst_outputs got r=%0b v=%0b d=%0d w=%0d want 1/0/0/0", din_ready, dout_valid, dout, dout_words); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    din = 8'h03; din_last = 1'b1; din_valid = 1'b1; @(negedge clk);
    din_valid = 1'b0; din_last = 1'b0;
    total++; if (dout_valid !== 1'b1 || dout !== CW'(2) || dout_words !== WW'(1) || dout_trunc !== 1'b0) begin bad++;
      $display("FAIL midrst_fresh got v=%0b d=%0d w=%0d t=%0b want 1/2/1/0", dout_valid, dout, dout_words, dout_trunc); end
    @(negedge clk);
  endtask

`ifdef FRAME_ONES_THRESH_EN
  task automatic test_thresh;
    dout_ready = 1'b1;
    thresh = CW'(10);
    din = 8'hFF; din_valid = 1'b1; @(negedge clk);
    din = 8'h03; din_last = 1'b1;  @(negedge clk);
    din_valid = 1'b0; din_last = 1'b0;
    total++; if (dout !== CW'(10) || dout_above !== 1'b0) begin bad++;
      $display("FAIL thresh_eq got d=%0d above=%0b want 10/0", dout, dout_above); end
    @(negedge clk);
    din = 8'hFF; din_valid = 1'b1; @(negedge clk);
    din = 8'h07; din_last = 1'b1;  @(negedge clk);
    din_valid = 1'b0; din_last = 1'b0;
    total++; if (dout !== CW'(11) || dout_above !== 1'b1) begin bad++;
      $display("FAIL thresh_above got d=%0d above=%0b want 11/1", dout, dout_above); end
    @(negedge clk);
  endtask
`endif

  // Frame-level reference: collect accepted words, close on last or word limit.
  task automatic test_random;
    bit holding = 0;
    int cur_sum = 0, cur_n = 0;
    int exp_sum = 0, exp_n = 0;
    bit exp_trunc = 0, exp_above = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      total++; if (dout_valid !== holding || din_ready !== !holding) begin bad++;
        $display("FAIL rand_handshake cyc=%0d got v=%0b r=%0b want v=%0b", cyc, dout_valid, din_ready, holding); end
      if (holding) begin
        total++; if (dout !== CW'(exp_sum) || dout_words !== WW'(exp_n) || dout_trunc !== exp_trunc) begin bad++;
          $display("FAIL rand_result cyc=%0d got d=%0d w=%0d t=%0b want %0d/%0d/%0b",
                   cyc, dout, dout_words, dout_trunc, exp_sum, exp_n, exp_trunc); end
`ifdef FRAME_ONES_THRESH_EN
        total++; if (dout_above !== exp_above) begin bad++;
          $display("FAIL rand_above cyc=%0d got=%0b want=%0b", cyc, dout_above, exp_above); end
`endif
      end
      din        = DW'($urandom);
      din_valid  = ($urandom_range(0, 99) < 70);
      din_last   = ($urandom_range(0, 99) < 25);
      dout_ready = ($urandom_range(0, 99) < 50);
`ifdef FRAME_ONES_THRESH_EN
      thresh = CW'($urandom_range(0, DW * MW));
`endif
      if (holding) begin
        if (dout_ready) holding = 0;
      end else if (din_valid) begin
        cur_sum += ones(din);
        cur_n++;
        if (din_last || cur_n == MW) begin
          exp_sum   = cur_sum;
          exp_n     = cur_n;
          exp_trunc = !din_last;
`ifdef FRAME_ONES_THRESH_EN
          exp_above = (cur_sum > int'(thresh));
`endif
          holding = 1;
          cur_sum = 0;
          cur_n   = 0;
        end
      end
    end
    @(negedge clk);
    din_valid = 1'b0; dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    if (exp_above) exp_above = 0;
  endtask

  initial begin
    resetn = 1'b0; din = '0; din_valid = 1'b0; din_last = 1'b0; dout_ready = 1'b0;
`ifdef FRAME_ONES_THRESH_EN
    thresh = '0;
`endif
    #1;
    test_reset;
    test_single_beat;
    test_bubbles;
    test_backpressure;
    test_truncation;
    test_reset_midframe;
`ifdef FRAME_ONES_THRESH_EN
    test_thresh;
`endif
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
